// File: rtl/sequence_checker.sv
// Checks the user's bit-by-bit re-entry of the LED sequence, with strikes and a per-entry timeout.
// Key and switch are synchronized on the same two-flop path so the bit value stays aligned with its press.
module sequence_checker #(
  parameter int SEQ_LEN       = 18,
  parameter int MAX_STRIKES   = 3,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SEQ_LEN-1:0] seq_in,
  input  logic               key_n,
  input  logic               bit_in,
  input  logic               tick,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         strikes,
  output logic [4:0]         position,
  output logic [7:0]         time_left
);

  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_PASS, ST_FAIL} state_t;

  localparam logic [7:0] TIMEOUT      = 8'(TIMEOUT_TICKS);
  localparam logic [4:0] LAST_POS     = 5'(SEQ_LEN - 1);
  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);

  state_t             state;
  logic [SEQ_LEN-1:0] seq_reg;
  logic [SEQ_LEN-1:0] seq_copy;
  logic               key_s1, key_s2, key_prev;
  logic               bit_s1, bit_s2;
  logic               press;
  logic               strike;
  logic [1:0]         strikes_inc;

  assign press       = !key_s2 && key_prev;
  assign strikes_inc = strikes + 2'd1;
  // A press always wins over a same-cycle tick, so a timeout only counts without a press.
  assign strike      = (state == ST_ENTRY) &&
                       ((press && (bit_s2 != seq_reg[0])) ||
                        (!press && tick && (time_left == 8'd1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      seq_reg   <= '0;
      seq_copy  <= '0;
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_prev  <= 1'b1;
      bit_s1    <= 1'b1;
      bit_s2    <= 1'b1;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      strikes   <= 2'd0;
      position  <= 5'd0;
      time_left <= 8'd0;
    end else begin
      key_s1   <= key_n;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      bit_s1   <= bit_in;
      bit_s2   <= bit_s1;

      case (state)
        ST_ENTRY: begin
          if (strike) begin
            strikes <= strikes_inc;
            if (strikes_inc == STRIKE_LIMIT) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              seq_reg   <= seq_copy;
              position  <= 5'd0;
              time_left <= TIMEOUT;
            end
          end else if (press) begin
            if (position == LAST_POS) begin
              state <= ST_PASS;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              seq_reg   <= seq_reg >> 1;
              position  <= position + 5'd1;
              time_left <= TIMEOUT;
            end
          end else if (tick) begin
            time_left <= time_left - 8'd1;
          end
        end
        default: begin
          if (start) begin
            state     <= ST_ENTRY;
            seq_reg   <= seq_in;
            seq_copy  <= seq_in;
            position  <= 5'd0;
            strikes   <= 2'd0;
            time_left <= TIMEOUT;
            pass      <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: correct entry, wrong bit, timeouts, press/tick collision,
// held key, sticky FAIL, start-while-busy and asynchronous reset mid-entry.
module tb_sequence_checker;

  logic        clock = 1'b0;
  logic        reset, start, key_n, bit_in, tick;
  logic [17:0] seq_in;
  logic        busy, pass, fail;
  logic [1:0]  strikes;
  logic [4:0]  position;
  logic [7:0]  time_left;

  logic [17:0] seq = 18'h2A5A5;
  int n_cmp = 0;
  int n_err = 0;

  sequence_checker #(.SEQ_LEN(18), .MAX_STRIKES(3), .TIMEOUT_TICKS(10)) dut (
    .clock(clock), .reset(reset), .start(start), .seq_in(seq_in),
    .key_n(key_n), .bit_in(bit_in), .tick(tick),
    .busy(busy), .pass(pass), .fail(fail), .strikes(strikes),
    .position(position), .time_left(time_left)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic b);
    bit_in = b;
    step(3);
    key_n = 1'b0;
    step(3);
    key_n = 1'b1;
    step(3);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_n = 1'b1; bit_in = 1'b0; tick = 1'b0;
    seq_in = seq;
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_busy", 32'(busy), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_strikes", 32'(strikes), 0);
    check("rst_position", 32'(position), 0);
    check("rst_time_left", 32'(time_left), 0);

    // correct entry, with the first press used to pin the three-edge latency
    pulse_start();
    check("start_busy", 32'(busy), 1);
    check("start_time_left", 32'(time_left), 10);
    bit_in = seq[0];
    step(3);
    key_n = 1'b0;
    step(2);
    check("lat_edge2_position", 32'(position), 0);
    step(1);
    check("lat_edge3_position", 32'(position), 1);
    key_n = 1'b1;
    step(3);
    for (int i = 1; i < 17; i++) begin
      press(seq[i]);
      check("ok_position", 32'(position), 32'(i + 1));
    end
    bit_in = seq[17];
    step(3);
    key_n = 1'b0;
    step(2);
    check("last_edge2_pass", 32'(pass), 0);
    step(1);
    check("last_pass", 32'(pass), 1);
    check("last_busy", 32'(busy), 0);
    check("last_position", 32'(position), 17);
    check("last_strikes", 32'(strikes), 0);
    key_n = 1'b1;
    step(3);

    // wrong bit at position 5, then a full correct entry
    pulse_start();
    check("wb_pass_cleared", 32'(pass), 0);
    for (int i = 0; i < 5; i++) press(seq[i]);
    check("wb_position5", 32'(position), 5);
    press(~seq[5]);
    check("wb_strikes", 32'(strikes), 1);
    check("wb_position", 32'(position), 0);
    check("wb_time_left", 32'(time_left), 10);
    check("wb_busy", 32'(busy), 1);
    for (int i = 0; i < 18; i++) press(seq[i]);
    check("wb2_pass", 32'(pass), 1);
    check("wb2_strikes", 32'(strikes), 1);
    check("wb2_busy", 32'(busy), 0);

    // press and tick in the same cycle at time_left == 1
    pulse_start();
    for (int k = 1; k <= 9; k++) pulse_tick();
    check("sim_time_left1", 32'(time_left), 1);
    bit_in = seq[0];
    step(3);
    key_n = 1'b0;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("sim_position", 32'(position), 1);
    check("sim_time_left", 32'(time_left), 10);
    check("sim_strikes", 32'(strikes), 0);
    key_n = 1'b1;
    step(3);
    pulse_tick();
    check("sim_tick_after", 32'(time_left), 9);

    // held key accepts exactly one entry
    bit_in = seq[1];
    step(3);
    key_n = 1'b0;
    step(1000);
    check("held_position", 32'(position), 2);
    key_n = 1'b1;
    step(3);
    check("held_release_position", 32'(position), 2);
    check("held_time_left", 32'(time_left), 10);

    // three timeouts in a row lead to FAIL
    for (int r = 1; r <= 3; r++) begin
      for (int k = 1; k <= 9; k++) begin
        pulse_tick();
        check("to_count", 32'(time_left), 32'(10 - k));
      end
      pulse_tick();
      check("to_strikes", 32'(strikes), 32'(r));
      if (r < 3) begin
        check("to_reload", 32'(time_left), 10);
        check("to_position", 32'(position), 0);
        check("to_busy", 32'(busy), 1);
      end else begin
        check("to_fail", 32'(fail), 1);
        check("to_fail_busy", 32'(busy), 0);
      end
    end

    // FAIL is sticky against ticks and presses
    pulse_tick();
    press(1'b1);
    press(1'b0);
    check("sticky_fail", 32'(fail), 1);
    check("sticky_strikes", 32'(strikes), 3);
    check("sticky_busy", 32'(busy), 0);
    check("sticky_pass", 32'(pass), 0);

    // restart, then start/seq_in changes while busy are ignored
    pulse_start();
    check("re_busy", 32'(busy), 1);
    check("re_strikes", 32'(strikes), 0);
    check("re_fail", 32'(fail), 0);
    check("re_position", 32'(position), 0);
    seq_in = ~seq;
    press(seq[0]);
    pulse_start();
    check("ign_start_position", 32'(position), 1);
    press(seq[1]);
    check("ign_seq_in_position", 32'(position), 2);
    check("ign_seq_in_strikes", 32'(strikes), 0);
    press(~seq[2]);
    check("ign_wrong_strikes", 32'(strikes), 1);
    press(seq[0]);
    pulse_tick();
    check("pre_rst_position", 32'(position), 1);
    check("pre_rst_time_left", 32'(time_left), 9);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_position", 32'(position), 0);
    check("arst_strikes", 32'(strikes), 0);
    check("arst_time_left", 32'(time_left), 0);
    step(2);
    reset = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Downstream consumer of the LED sequence player in the defuse game: the player's 18-bit sequence is shown on LEDs, then the user re-enters it bit by bit (switch = bit value, pushbutton = commit).
- Block compares each entry against the same sequence word, counts strikes, enforces a per-entry timeout driven by the rate-divider tick, and reports sticky pass/fail to the game controller.

Parameters:
- SEQ_LEN, 18, number of bits to enter (2..31)
- MAX_STRIKES, 3, wrong entries/timeouts before fail (1..3)
- TIMEOUT_TICKS, 10, tick periods allowed per entry (1..255)

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: load seq_in and begin entry
- seq_in  in  SEQ_LEN  expected sequence; bit 0 entered first (same order the player shows)
- key_n  in  1  raw pushbutton, active-low, asynchronous
- bit_in  in  1  raw switch giving the entered bit value, asynchronous
- tick  in  1  one-cycle enable from rate divider (about 1 Hz)
- busy  out  1  high in ENTRY state
- pass  out  1  sticky: full sequence entered correctly
- fail  out  1  sticky: strikes reached MAX_STRIKES
- strikes  out  2  strikes so far
- position  out  5  index of next bit expected (0..SEQ_LEN-1)
- time_left  out  8  ticks remaining for current entry

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, pass=0, fail=0, strikes=0, position=0, time_left=0. Synchronizer flops are set to 1 (released key).
- key_n and bit_in each pass through a 2-flop synchronizer. press = (synced key_n==0) && (previous synced key_n==1).
- Latency: if key_n falls before clock edge N, its effect is visible in registered outputs after edge N+2. bit_in is sampled on the same path, so the bit value and press stay aligned.
- A held key produces exactly one press. No debounce in this block; the board key is assumed clean enough at this stage.
- States: IDLE, ENTRY, PASS, FAIL.
- IDLE / PASS / FAIL, on start:
  - seq_reg <= seq_in; position <= 0; strikes <= 0; time_left <= TIMEOUT_TICKS; pass <= 0; fail <= 0; go to ENTRY.
  - Otherwise hold all outputs. pass and fail are sticky.
- ENTRY, on press with bit_in == seq_reg[0]:
  - If position == SEQ_LEN-1: go to PASS (pass=1, busy=0). position and time_left hold their values.
  - Else: seq_reg shifts right by 1; position increments; time_left <= TIMEOUT_TICKS.
- ENTRY, on press with a wrong bit, or on tick with time_left==1 and no press (timeout):
  - This is a strike: strikes increments.
  - If the new strike count == MAX_STRIKES: go to FAIL (fail=1, busy=0).
  - Else restart from bit 0: seq_reg reloads from the value latched at start (a separate copy is kept); position <= 0; time_left <= TIMEOUT_TICKS.
- ENTRY, on tick with time_left > 1 and no press: time_left decrements.
- Press and tick in the same cycle: only the press is processed and the tick is dropped.
- start while in ENTRY: ignored. seq_in changes after start have no effect.
- reset mid-entry: immediately returns to IDLE with all outputs cleared, as described above.
- tick in IDLE / PASS / FAIL: ignored.
- Widths: time_left is 8 bits and never wraps (the minimum before reload is 1). strikes saturates at MAX_STRIKES.

Test Plan:
- Correct entry: reset, start with seq_in=18'h2A5A5, then 18 presses matching bits 0..17 (bit_in stable for at least 3 cycles before each press) -> position steps 0..17, pass=1 on the third edge after the final press, strikes=0, busy=0.
- Wrong bit: at position 5, enter the inverse bit -> strikes=1, position=0, time_left=10; then a full correct entry -> pass=1, strikes=1.
- Timeout: start, then 10 ticks with no press -> time_left counts 10..1, strikes=1, time_left=10. Repeat twice more -> fail=1, strikes=3, busy=0.
- Simultaneous events: correct press lands in the same cycle as a tick at time_left=1 -> no strike, position increments, time_left=10.
- Held key: key_n held low for 1000 cycles -> exactly one entry accepted (position +1).
- Sticky and reset: in FAIL, pulse tick and key -> outputs unchanged. Then start -> ENTRY with strikes=0, fail=0. Assert reset mid-entry (asynchronous, between edges) -> busy, position, strikes and time_left read 0 before the next edge.
